// File: rtl/seq_pattern_counter_if.sv
// Serial-in / status-out bundle of seq_pattern_counter.
// CNT_W must match the CNT_W of the counter instance it connects to.
interface seq_pattern_counter_if #(
  parameter int CNT_W = 4
) ();
  logic             data_valid;
  logic             data;
  logic             clear;
  logic             match;
  logic [CNT_W-1:0] count;
  logic             armed;

  modport master (
    output data_valid, data, clear,
    input  match, count, armed
  );

  modport slave (
    input  data_valid, data, clear,
    output match, count, armed
  );
endinterface

// File: rtl/seq_pattern_counter.sv
// Serial pattern detector with occurrence counter, overlap/non-overlap mode and match pulse.
// Define SEQ_PATTERN_COUNTER_SAT_EN to make the counter saturate instead of wrap.
module seq_pattern_counter #(
  parameter int               PAT_W   = 3,
  parameter logic [PAT_W-1:0] PATTERN = 3'b111,
  parameter int               CNT_W   = 4,
  parameter bit               OVERLAP = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  seq_pattern_counter_if.slave bus
);
  localparam int               FILL_W   = $clog2(PAT_W + 1);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W);
  localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};

  typedef enum logic [0:0] {
    ST_FILL  = 1'b0,
    ST_ARMED = 1'b1
  } state_t;

  state_t             r_state;
  logic [PAT_W-1:0]   r_hist;
  logic [FILL_W-1:0]  r_fill;
  logic [CNT_W-1:0]   r_count;
  logic               r_match;
  logic               r_armed;

  state_t             w_state_nxt;
  logic [PAT_W-1:0]   w_hist_sh;
  logic [PAT_W-1:0]   w_hist_nxt;
  logic [FILL_W-1:0]  w_fill_inc;
  logic [FILL_W-1:0]  w_fill_nxt;
  logic [CNT_W-1:0]   w_count_nxt;
  logic               w_hit;

  // Next-state, history, fill and count; clear outranks the qualified sample.
  always_comb begin
    w_state_nxt = r_state;
    w_hist_nxt  = r_hist;
    w_fill_nxt  = r_fill;
    w_count_nxt = r_count;
    w_hit       = 1'b0;
    w_hist_sh   = {r_hist[PAT_W-2:0], bus.data};
    w_fill_inc  = (r_fill == FILL_MAX) ? r_fill : (r_fill + FILL_W'(1));

    if (bus.clear) begin
      w_state_nxt = ST_FILL;
      w_hist_nxt  = {PAT_W{1'b0}};
      w_fill_nxt  = {FILL_W{1'b0}};
      w_count_nxt = {CNT_W{1'b0}};
    end else if (bus.data_valid) begin
      w_hist_nxt = w_hist_sh;
      w_fill_nxt = w_fill_inc;
      // The bit that completes the fill is already eligible to match.
      case (r_state)
        ST_FILL: begin
          if (w_fill_inc == FILL_MAX) begin
            w_state_nxt = ST_ARMED;
            w_hit       = (w_hist_sh == PATTERN);
          end else begin
            w_state_nxt = ST_FILL;
          end
        end
        ST_ARMED: begin
          w_state_nxt = ST_ARMED;
          w_hit       = (w_hist_sh == PATTERN);
        end
        default: begin
          w_state_nxt = ST_FILL;
        end
      endcase

      if (w_hit && (OVERLAP == 1'b0)) begin
        w_state_nxt = ST_FILL;
        w_hist_nxt  = {PAT_W{1'b0}};
        w_fill_nxt  = {FILL_W{1'b0}};
      end else begin
        w_hist_nxt = w_hist_nxt;
      end

      if (w_hit) begin
`ifdef SEQ_PATTERN_COUNTER_SAT_EN
        w_count_nxt = (r_count == CNT_MAX) ? r_count : (r_count + CNT_W'(1));
`else
        w_count_nxt = r_count + CNT_W'(1);
`endif
      end else begin
        w_count_nxt = r_count;
      end
    end else begin
      w_hit = 1'b0;
    end
  end

  // State register and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_FILL;
      r_hist  <= {PAT_W{1'b0}};
      r_fill  <= {FILL_W{1'b0}};
      r_count <= {CNT_W{1'b0}};
      r_match <= 1'b0;
      r_armed <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_hist  <= w_hist_nxt;
      r_fill  <= w_fill_nxt;
      r_count <= w_count_nxt;
      r_match <= w_hit;
      r_armed <= (w_state_nxt == ST_ARMED);
    end
  end

  assign bus.match = r_match;
  assign bus.count = r_count;
  assign bus.armed = r_armed;
endmodule

// File: tb/tb_seq_pattern_counter.sv
// Self-checking bench: four seq_pattern_counter configurations driven in lock-step,
// a behavioural scoreboard for every cycle plus table and directed corner sequences.
module tb_seq_pattern_counter;
  logic clk;
  logic reset;

  seq_pattern_counter_if #(.CNT_W(4)) if0 ();
  seq_pattern_counter_if #(.CNT_W(4)) if1 ();
  seq_pattern_counter_if #(.CNT_W(2)) if2 ();
  seq_pattern_counter_if #(.CNT_W(4)) if3 ();

  seq_pattern_counter #(.PAT_W(3), .PATTERN(3'b111), .CNT_W(4), .OVERLAP(1'b1))
    u0 (.clk(clk), .reset(reset), .bus(if0.slave));
  seq_pattern_counter #(.PAT_W(3), .PATTERN(3'b111), .CNT_W(4), .OVERLAP(1'b0))
    u1 (.clk(clk), .reset(reset), .bus(if1.slave));
  seq_pattern_counter #(.PAT_W(3), .PATTERN(3'b111), .CNT_W(2), .OVERLAP(1'b1))
    u2 (.clk(clk), .reset(reset), .bus(if2.slave));
  seq_pattern_counter #(.PAT_W(4), .PATTERN(4'b1010), .CNT_W(4), .OVERLAP(1'b1))
    u3 (.clk(clk), .reset(reset), .bus(if3.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic        act_m [4];
  logic [15:0] act_c [4];
  logic        act_a [4];
  assign act_m[0] = if0.match;  assign act_c[0] = 16'(if0.count);  assign act_a[0] = if0.armed;
  assign act_m[1] = if1.match;  assign act_c[1] = 16'(if1.count);  assign act_a[1] = if1.armed;
  assign act_m[2] = if2.match;  assign act_c[2] = 16'(if2.count);  assign act_a[2] = if2.armed;
  assign act_m[3] = if3.match;  assign act_c[3] = 16'(if3.count);  assign act_a[3] = if3.armed;

  // Reference configuration of each instance
  int pw  [4] = '{3, 3, 3, 4};
  int pat [4] = '{7, 7, 7, 10};
  int cw  [4] = '{4, 4, 2, 4};
  bit ov  [4] = '{1'b1, 1'b0, 1'b1, 1'b1};

  int m_h [4];
  int m_f [4];
  int m_c [4];
  bit m_a [4];

  typedef struct {
    int dut;
    bit m;
    int c;
    bit a;
  } exp_t;
  exp_t sb_q [$];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Advance the reference model for one edge and queue the expected outputs.
  task automatic model_step(input bit v, input bit d, input bit c, input bit r);
    for (int k = 0; k < 4; k++) begin
      bit mm;
      int cmax;
      exp_t e;
      mm   = 1'b0;
      cmax = (1 << cw[k]) - 1;
      if (r || c) begin
        m_h[k] = 0; m_f[k] = 0; m_c[k] = 0; m_a[k] = 1'b0;
      end else if (v) begin
        m_h[k] = ((m_h[k] << 1) | int'(d)) & ((1 << pw[k]) - 1);
        if (m_f[k] < pw[k]) m_f[k]++;
        if (m_f[k] == pw[k] && m_h[k] == pat[k]) begin
          mm = 1'b1;
`ifdef SEQ_PATTERN_COUNTER_SAT_EN
          if (m_c[k] < cmax) m_c[k]++;
`else
          m_c[k] = (m_c[k] + 1) & cmax;
`endif
          if (!ov[k]) begin
            m_h[k] = 0; m_f[k] = 0;
          end
        end
        m_a[k] = (m_f[k] == pw[k]);
      end
      e.dut = k; e.m = mm; e.c = m_c[k]; e.a = m_a[k];
      sb_q.push_back(e);
    end
  endtask

  task automatic step(input bit v, input bit d, input bit c, input bit r);
    if0.data_valid = v; if0.data = d; if0.clear = c;
    if1.data_valid = v; if1.data = d; if1.clear = c;
    if2.data_valid = v; if2.data = d; if2.clear = c;
    if3.data_valid = v; if3.data = d; if3.clear = c;
    reset = r;
    model_step(v, d, c, r);
    @(posedge clk);
    @(negedge clk);
  endtask

  // Scoreboard: pop the expectations of the edge just taken.
  always @(posedge clk) begin
    #1;
    while (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      chk($sformatf("sb_match[u%0d]", e.dut), int'(act_m[e.dut]), int'(e.m));
      chk($sformatf("sb_count[u%0d]", e.dut), int'(act_c[e.dut]), e.c);
      chk($sformatf("sb_armed[u%0d]", e.dut), int'(act_a[e.dut]), int'(e.a));
    end
  end

  typedef struct {
    bit v;
    bit d;
    bit c;
    bit em;
    int ec;
    bit ea;
  } vec_t;
  vec_t tbl [15];

  int sat_exp [5];

  initial begin
    tbl[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b0};
    tbl[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b0};
    tbl[2]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1, 1'b1};
    tbl[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1, 1'b1};
    tbl[4]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1, 1'b1};
    tbl[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1, 1'b1};
    tbl[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1, 1'b1};
    tbl[7]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1, 1'b1};
    tbl[8]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1, 1'b1};
    tbl[9]  = '{1'b1, 1'b1, 1'b0, 1'b1, 2, 1'b1};
    tbl[10] = '{1'b1, 1'b1, 1'b0, 1'b1, 3, 1'b1};
    tbl[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 3, 1'b1};
    tbl[12] = '{1'b1, 1'b0, 1'b0, 1'b0, 3, 1'b1};
    tbl[13] = '{1'b1, 1'b0, 1'b0, 1'b0, 3, 1'b1};
    tbl[14] = '{1'b1, 1'b0, 1'b0, 1'b0, 3, 1'b1};
`ifdef SEQ_PATTERN_COUNTER_SAT_EN
    sat_exp = '{1, 2, 3, 3, 3};
`else
    sat_exp = '{1, 2, 3, 0, 1};
`endif
    for (int k = 0; k < 4; k++) begin
      m_h[k] = 0; m_f[k] = 0; m_c[k] = 0; m_a[k] = 1'b0;
    end

    // Reset for two cycles
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("rst_match[u%0d]", k), int'(act_m[k]), 0);
      chk($sformatf("rst_count[u%0d]", k), int'(act_c[k]), 0);
      chk($sformatf("rst_armed[u%0d]", k), int'(act_a[k]), 0);
    end

    // Reference stream on the default instance
    for (int i = 0; i < 15; i++) begin
      step(tbl[i].v, tbl[i].d, tbl[i].c, 1'b0);
      chk($sformatf("tbl_match[%0d]", i), int'(act_m[0]), int'(tbl[i].em));
      chk($sformatf("tbl_count[%0d]", i), int'(act_c[0]), tbl[i].ec);
      chk($sformatf("tbl_armed[%0d]", i), int'(act_a[0]), int'(tbl[i].ea));
    end

    // Non-overlap: six ones give two hits, then a partial pattern is cleared
    step(1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 1'b1, 1'b0, 1'b0);
      chk($sformatf("novl_match[%0d]", i), int'(act_m[1]), (i == 2 || i == 5) ? 1 : 0);
    end
    chk("novl_count", int'(act_c[1]), 2);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("novl_clr_count", int'(act_c[1]), 0);
    chk("novl_clr_armed", int'(act_a[1]), 0);

    // Sparse valid: one single-cycle pulse, nothing while idle
    step(1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, 1'b0, 1'b0);
      chk($sformatf("gap_match_bit[%0d]", i), int'(act_m[0]), (i == 2) ? 1 : 0);
      for (int j = 0; j < 4; j++) begin
        step(1'b0, 1'b1, 1'b0, 1'b0);
        chk($sformatf("gap_idle_match[%0d.%0d]", i, j), int'(act_m[0]), 0);
      end
    end
    chk("gap_count", int'(act_c[0]), 1);

    // Narrow counter: five overlapping hits
    step(1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 7; i++) begin
      step(1'b1, 1'b1, 1'b0, 1'b0);
      if (i >= 2) begin
        chk($sformatf("ovf_count[%0d]", i - 2), int'(act_c[2]), sat_exp[i - 2]);
        chk($sformatf("ovf_match[%0d]", i - 2), int'(act_m[2]), 1);
      end
    end

    // Reset in the middle of a pattern discards the partial history
    step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    chk("prst_match", int'(act_m[0]), 0);
    chk("prst_armed", int'(act_a[0]), 0);
    chk("prst_count", int'(act_c[0]), 0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    chk("prst_match2", int'(act_m[0]), 0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    chk("prst_match3", int'(act_m[0]), 1);
    chk("prst_count3", int'(act_c[0]), 1);

    // 4-bit pattern 1010 with overlap
    step(1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) begin
      step(1'b1, (i % 2 == 0) ? 1'b1 : 1'b0, 1'b0, 1'b0);
      chk($sformatf("p1010_match[%0d]", i), int'(act_m[3]), (i == 3 || i == 5) ? 1 : 0);
    end
    chk("p1010_count", int'(act_c[3]), 2);

    // Clear coinciding with a completing bit drops the hit
    step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    chk("clrhit_match", int'(act_m[0]), 0);
    chk("clrhit_count", int'(act_c[0]), 0);
    chk("clrhit_armed", int'(act_a[0]), 0);

    step(1'b0, 1'b0, 1'b0, 1'b0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
